tage_bank: RTL and testbench

Tagged TAGE component bank, the successor to the 2-bit tagged table. It adds:
- parametrised prediction-counter width
- per-entry useful counters
- allocation arbitration based on the useful counter
- a 1-cycle registered prediction read
- a periodic useful-counter aging sweep FSM

---
 rtl/tage_pkg.sv | 47 ++++
 rtl/tage_u_aging.sv | 53 +++++
 rtl/tage_bank.sv | 176 +++++++++++++++++
 tb/tb_tage_bank.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tage_pkg.sv
// Shared types and helpers for the tagged TAGE bank.
// Entry layout, aging FSM states and saturating counter arithmetic.
package tage_pkg;

  localparam int TAGE_TAG_W = 8;
  localparam int TAGE_CTR_W = 3;
  localparam int TAGE_U_W   = 2;

  typedef struct packed {
    logic                  valid;
    logic [TAGE_TAG_W-1:0] tag;
    logic [TAGE_CTR_W-1:0] ctr;
    logic [TAGE_U_W-1:0]   u;
  } tage_entry_t;

  typedef enum logic {
    AGE_IDLE,
    AGE_SWEEP
  } age_state_e;

  function automatic logic [31:0] sat_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input int unsigned w
  );
    return (v >= sat_max(w)) ? sat_max(w) : v + 32'd1;
  endfunction

  function automatic logic [31:0] sat_dec(
    input logic [31:0] v,
    input int unsigned w
  );
    return (v == 32'd0) ? 32'd0 : (v - 32'd1) & sat_max(w);
  endfunction

  function automatic logic [31:0] weak_t(input int unsigned w);
    return 32'd1 << (w - 1);
  endfunction

  function automatic logic [31:0] weak_nt(input int unsigned w);
    return weak_t(w) - 32'd1;
  endfunction

endpackage

// File: rtl/tage_u_aging.sv
// Useful-counter aging: counts updates, then sweeps every entry once
// per AGE_PERIOD updates, one entry per cycle.
module tage_u_aging #(
  parameter  int ENTRIES    = 64,
  parameter  int AGE_PERIOD = 256,
  localparam int IDX_W      = $clog2(ENTRIES)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             upd_valid_i,
  output logic             sweep_valid_o,
  output logic [IDX_W-1:0] sweep_idx_o
);
  import tage_pkg::*;

  localparam int AGE_W = $clog2(AGE_PERIOD);

  logic [AGE_W-1:0] r_age;
  logic [IDX_W-1:0] r_idx;
  age_state_e       r_state;
  age_state_e       w_state_nx;
  logic             w_wrap;
  logic             w_last;

  assign w_wrap = upd_valid_i && (r_age == AGE_W'(AGE_PERIOD - 1));
  assign w_last = (r_idx == IDX_W'(ENTRIES - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_age   <= '0;
      r_idx   <= '0;
      r_state <= AGE_IDLE;
    end else begin
      if (upd_valid_i) r_age <= r_age + 1'b1;
      r_state <= w_state_nx;
      if (r_state == AGE_SWEEP) r_idx <= r_idx + 1'b1;
      else                      r_idx <= '0;
    end
  end

  // A wrap seen mid-sweep is dropped, never queued.
  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      AGE_IDLE:  if (w_wrap) w_state_nx = AGE_SWEEP;
      AGE_SWEEP: if (w_last) w_state_nx = AGE_IDLE;
    endcase
  end

  assign sweep_valid_o = (r_state == AGE_SWEEP);
  assign sweep_idx_o   = r_idx;

endmodule

// File: rtl/tage_bank.sv
// Tagged TAGE bank: registered multi-lane lookup, commit-side update,
// u-based allocation and periodic u aging. Perf counters: TAGE_BANK_PERF_EN.
module tage_bank #(
  parameter  int INSTR_PER_FETCH = 4,
  parameter  int ENTRIES         = 64,
  parameter  int TAG_BITS        = 8,
  parameter  int CTR_BITS        = 3,
  parameter  int U_BITS          = 2,
  parameter  int AGE_PERIOD      = 256,
  localparam int IDX_W           = $clog2(ENTRIES)
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic                                      predict_valid_i,
  input  logic [INSTR_PER_FETCH-1:0][IDX_W-1:0]     predict_idx_i,
  input  logic [INSTR_PER_FETCH-1:0][TAG_BITS-1:0]  predict_tag_i,
  output logic [INSTR_PER_FETCH-1:0]                predict_hit_o,
  output logic [INSTR_PER_FETCH-1:0][CTR_BITS-1:0]  predict_ctr_o,
  output logic [INSTR_PER_FETCH-1:0][U_BITS-1:0]    predict_u_o,
  input  logic                                      update_valid_i,
  input  logic [IDX_W-1:0]                          update_idx_i,
  input  logic [TAG_BITS-1:0]                       update_tag_i,
  input  logic                                      update_taken_i,
  input  logic                                      update_alloc_i,
  input  logic                                      update_u_inc_i,
  input  logic                                      update_u_dec_i,
  output logic                                      update_hit_o,
  output logic                                      alloc_ok_o,
  output logic                                      alloc_fail_o,
  output logic                                      aging_busy_o
`ifdef TAGE_BANK_PERF_EN
  ,
  output logic [31:0]                               perf_alloc_ok_o,
  output logic [31:0]                               perf_alloc_fail_o,
  output logic [31:0]                               perf_hit_update_o
`endif
);
  import tage_pkg::*;

  localparam tage_entry_t RST_ENTRY = '{
    valid: 1'b0,
    tag:   '0,
    ctr:   CTR_BITS'(weak_nt(CTR_BITS)),
    u:     '0
  };

  tage_entry_t r_tbl [ENTRIES];
  tage_entry_t w_ue;
  tage_entry_t w_pe  [INSTR_PER_FETCH];

  logic [INSTR_PER_FETCH-1:0]               r_hit;
  logic [INSTR_PER_FETCH-1:0][CTR_BITS-1:0] r_ctr;
  logic [INSTR_PER_FETCH-1:0][U_BITS-1:0]   r_u;
  logic                                     r_ok;
  logic                                     r_fail;

  logic             w_sweep_valid;
  logic [IDX_W-1:0] w_sweep_idx;
  logic             w_can_alloc;
  logic             w_do_alloc;
  logic             w_do_fail;
  logic             w_do_hit;
  logic             w_u_wr;
  logic             w_shift;
  logic [CTR_BITS-1:0] w_ctr_nx;
  logic [CTR_BITS-1:0] w_ctr_alloc;
  logic [U_BITS-1:0]   w_u_nx;

  tage_u_aging #(
    .ENTRIES    (ENTRIES),
    .AGE_PERIOD (AGE_PERIOD)
  ) u_aging (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .upd_valid_i   (update_valid_i),
    .sweep_valid_o (w_sweep_valid),
    .sweep_idx_o   (w_sweep_idx)
  );

  assign w_ue         = r_tbl[update_idx_i];
  assign update_hit_o = w_ue.valid && (w_ue.tag == update_tag_i);
  assign w_can_alloc  = !w_ue.valid || (w_ue.u == '0);
  assign w_do_alloc   = update_valid_i && update_alloc_i && w_can_alloc;
  assign w_do_fail    = update_valid_i && update_alloc_i && !w_can_alloc;
  assign w_do_hit     = update_valid_i && !update_alloc_i && update_hit_o;

  // Any update touching u of the swept entry supersedes its shift.
  assign w_u_wr  = w_do_alloc || w_do_fail ||
                   (w_do_hit && (update_u_inc_i ^ update_u_dec_i));
  assign w_shift = w_sweep_valid &&
                   !(w_u_wr && (update_idx_i == w_sweep_idx));

  always_comb begin
    w_ctr_alloc = update_taken_i ? CTR_BITS'(weak_t(CTR_BITS))
                                 : CTR_BITS'(weak_nt(CTR_BITS));
    w_ctr_nx = update_taken_i ? CTR_BITS'(sat_inc(32'(w_ue.ctr), CTR_BITS))
                              : CTR_BITS'(sat_dec(32'(w_ue.ctr), CTR_BITS));
    if (w_do_alloc)
      w_u_nx = '0;
    else if (w_do_fail || update_u_dec_i)
      w_u_nx = U_BITS'(sat_dec(32'(w_ue.u), U_BITS));
    else
      w_u_nx = U_BITS'(sat_inc(32'(w_ue.u), U_BITS));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) r_tbl[i] <= RST_ENTRY;
    end else begin
      if (w_shift)
        r_tbl[w_sweep_idx].u <= r_tbl[w_sweep_idx].u >> 1;
      if (w_do_alloc) begin
        r_tbl[update_idx_i].valid <= 1'b1;
        r_tbl[update_idx_i].tag   <= update_tag_i;
        r_tbl[update_idx_i].ctr   <= w_ctr_alloc;
      end
      if (w_do_hit) r_tbl[update_idx_i].ctr <= w_ctr_nx;
      if (w_u_wr)   r_tbl[update_idx_i].u   <= w_u_nx;
    end
  end

  always_comb begin
    for (int l = 0; l < INSTR_PER_FETCH; l++)
      w_pe[l] = r_tbl[predict_idx_i[l]];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_hit  <= '0;
      r_ctr  <= '0;
      r_u    <= '0;
      r_ok   <= 1'b0;
      r_fail <= 1'b0;
    end else begin
      r_ok   <= w_do_alloc;
      r_fail <= w_do_fail;
      if (predict_valid_i) begin
        for (int l = 0; l < INSTR_PER_FETCH; l++) begin
          r_hit[l] <= w_pe[l].valid && (w_pe[l].tag == predict_tag_i[l]);
          r_ctr[l] <= w_pe[l].ctr;
          r_u[l]   <= w_pe[l].u;
        end
      end
    end
  end

  assign predict_hit_o = r_hit;
  assign predict_ctr_o = r_ctr;
  assign predict_u_o   = r_u;
  assign alloc_ok_o    = r_ok;
  assign alloc_fail_o  = r_fail;
  assign aging_busy_o  = w_sweep_valid;

`ifdef TAGE_BANK_PERF_EN
  logic [31:0] r_perf_ok;
  logic [31:0] r_perf_fail;
  logic [31:0] r_perf_hit;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_perf_ok   <= '0;
      r_perf_fail <= '0;
      r_perf_hit  <= '0;
    end else begin
      if (w_do_alloc) r_perf_ok   <= r_perf_ok + 32'd1;
      if (w_do_fail)  r_perf_fail <= r_perf_fail + 32'd1;
      if (w_do_hit)   r_perf_hit  <= r_perf_hit + 32'd1;
    end
  end

  assign perf_alloc_ok_o   = r_perf_ok;
  assign perf_alloc_fail_o = r_perf_fail;
  assign perf_hit_update_o = r_perf_hit;
`endif

endmodule

// File: tb/tb_tage_bank.sv
// Scoreboard bench for tage_bank with default parameters.
// Expected lookups/alloc pulses are queued at drive time, popped after the edge.
module tb_tage_bank;

  typedef struct packed {
    logic [3:0]      hit;
    logic [3:0][2:0] ctr;
    logic [3:0][1:0] u;
  } pred_t;

  typedef struct packed {
    logic ok;
    logic fail;
  } upd_t;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            predict_valid_i;
  logic [3:0][5:0] predict_idx_i;
  logic [3:0][7:0] predict_tag_i;
  logic [3:0]      predict_hit_o;
  logic [3:0][2:0] predict_ctr_o;
  logic [3:0][1:0] predict_u_o;
  logic            update_valid_i;
  logic [5:0]      update_idx_i;
  logic [7:0]      update_tag_i;
  logic            update_taken_i;
  logic            update_alloc_i;
  logic            update_u_inc_i;
  logic            update_u_dec_i;
  logic            update_hit_o;
  logic            alloc_ok_o;
  logic            alloc_fail_o;
  logic            aging_busy_o;
`ifdef TAGE_BANK_PERF_EN
  logic [31:0]     perf_alloc_ok_o;
  logic [31:0]     perf_alloc_fail_o;
  logic [31:0]     perf_hit_update_o;
`endif

  pred_t pq[$];
  upd_t  uq[$];
  int    n_checks = 0;
  int    n_errors = 0;

  always #5 clk_i = ~clk_i;

  tage_bank dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .predict_valid_i (predict_valid_i),
    .predict_idx_i   (predict_idx_i),
    .predict_tag_i   (predict_tag_i),
    .predict_hit_o   (predict_hit_o),
    .predict_ctr_o   (predict_ctr_o),
    .predict_u_o     (predict_u_o),
    .update_valid_i  (update_valid_i),
    .update_idx_i    (update_idx_i),
    .update_tag_i    (update_tag_i),
    .update_taken_i  (update_taken_i),
    .update_alloc_i  (update_alloc_i),
    .update_u_inc_i  (update_u_inc_i),
    .update_u_dec_i  (update_u_dec_i),
    .update_hit_o    (update_hit_o),
    .alloc_ok_o      (alloc_ok_o),
    .alloc_fail_o    (alloc_fail_o),
    .aging_busy_o    (aging_busy_o)
`ifdef TAGE_BANK_PERF_EN
    ,
    .perf_alloc_ok_o   (perf_alloc_ok_o),
    .perf_alloc_fail_o (perf_alloc_fail_o),
    .perf_hit_update_o (perf_hit_update_o)
`endif
  );

  task automatic check(input string t, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", t, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    tick();
  endtask

  task automatic predict(input string t, input bit pv,
                         input logic [3:0][5:0] idx,
                         input logic [3:0][7:0] tg,
                         input logic [3:0] eh,
                         input logic [3:0][2:0] ec,
                         input logic [3:0][1:0] eu);
    pred_t e;
    predict_valid_i = pv;
    predict_idx_i   = idx;
    predict_tag_i   = tg;
    e.hit = eh;
    e.ctr = ec;
    e.u   = eu;
    pq.push_back(e);
    tick();
    predict_valid_i = 1'b0;
    e = pq.pop_front();
    check({t, ".hit"}, 32'(predict_hit_o), 32'(e.hit));
    check({t, ".ctr"}, 32'(predict_ctr_o), 32'(e.ctr));
    check({t, ".u"},   32'(predict_u_o),   32'(e.u));
  endtask

  task automatic p1(input string t, input logic [5:0] idx,
                    input logic [7:0] tg, input logic eh,
                    input logic [2:0] ec, input logic [1:0] eu);
    predict(t, 1'b1, {4{idx}}, {4{tg}}, {4{eh}}, {4{ec}}, {4{eu}});
  endtask

  task automatic upd(input string t, input logic [5:0] idx,
                     input logic [7:0] tg, input bit tk, input bit al,
                     input bit inc, input bit dec, input bit eh,
                     input bit eok, input bit efail);
    upd_t e;
    update_valid_i = 1'b1;
    update_idx_i   = idx;
    update_tag_i   = tg;
    update_taken_i = tk;
    update_alloc_i = al;
    update_u_inc_i = inc;
    update_u_dec_i = dec;
    #1;
    check({t, ".uhit"}, 32'(update_hit_o), 32'(eh));
    e.ok   = eok;
    e.fail = efail;
    uq.push_back(e);
    tick();
    update_valid_i = 1'b0;
    e = uq.pop_front();
    check({t, ".ok"},   32'(alloc_ok_o),   32'(e.ok));
    check({t, ".fail"}, 32'(alloc_fail_o), 32'(e.fail));
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++)
      upd("fill", 6'd63, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wait_idle(input string t);
    int c = 0;
    while (aging_busy_o && c < 200) begin
      tick();
      c++;
    end
    check(t, 32'(aging_busy_o), 32'd0);
  endtask

  initial begin
    int cnt;
    rst_i           = 1'b1;
    predict_valid_i = 1'b0;
    predict_idx_i   = '0;
    predict_tag_i   = '0;
    update_valid_i  = 1'b0;
    update_idx_i    = '0;
    update_tag_i    = '0;
    update_taken_i  = 1'b0;
    update_alloc_i  = 1'b0;
    update_u_inc_i  = 1'b0;
    update_u_dec_i  = 1'b0;
    tick();
    tick();
    check("rst.hit",  32'(predict_hit_o), 32'd0);
    check("rst.ctr",  32'(predict_ctr_o), 32'd0);
    check("rst.ok",   32'(alloc_ok_o),    32'd0);
    check("rst.fail", 32'(alloc_fail_o),  32'd0);
    check("rst.busy", 32'(aging_busy_o),  32'd0);
    rst_i = 1'b0;
    tick();

    p1("rst_pred", 6'd5, 8'h3A, 1'b0, 3'd3, 2'd0);
    upd("alloc1", 6'd5, 8'h3A, 1, 1, 0, 0, 0, 1, 0);
    p1("alloc_pred", 6'd5, 8'h3A, 1'b1, 3'd4, 2'd0);
    predict("hold", 1'b0, {4{6'd6}}, {4{8'h00}},
            4'hF, {4{3'd4}}, {4{2'd0}});
    repeat (3) upd("tk", 6'd5, 8'h3A, 1, 0, 0, 0, 1, 0, 0);
    p1("ctr7", 6'd5, 8'h3A, 1'b1, 3'd7, 2'd0);
    upd("tk4", 6'd5, 8'h3A, 1, 0, 0, 0, 1, 0, 0);
    p1("ctr_sat", 6'd5, 8'h3A, 1'b1, 3'd7, 2'd0);
    repeat (4) upd("uinc", 6'd5, 8'h3A, 1, 0, 1, 0, 1, 0, 0);
    p1("u_sat", 6'd5, 8'h3A, 1'b1, 3'd7, 2'd3);
    upd("both", 6'd5, 8'h3A, 0, 0, 1, 1, 1, 0, 0);
    p1("both_pred", 6'd5, 8'h3A, 1'b1, 3'd6, 2'd3);
    upd("afail1", 6'd5, 8'h11, 1, 1, 0, 0, 0, 0, 1);
    p1("afail1_old", 6'd5, 8'h3A, 1'b1, 3'd6, 2'd2);
    p1("afail1_new", 6'd5, 8'h11, 1'b0, 3'd6, 2'd2);
    upd("afail2", 6'd5, 8'h11, 1, 1, 1, 0, 0, 0, 1);
    upd("afail3", 6'd5, 8'h11, 1, 1, 0, 0, 0, 0, 1);
    p1("afail3_pred", 6'd5, 8'h3A, 1'b1, 3'd6, 2'd0);
    upd("aok2", 6'd5, 8'h11, 0, 1, 0, 0, 0, 1, 0);
    p1("aok2_new", 6'd5, 8'h11, 1'b1, 3'd3, 2'd0);
    p1("aok2_old", 6'd5, 8'h3A, 1'b0, 3'd3, 2'd0);
    upd("miss", 6'd5, 8'h3A, 1, 0, 1, 0, 0, 0, 0);
    p1("miss_pred", 6'd5, 8'h11, 1'b1, 3'd3, 2'd0);
    upd("dec0", 6'd5, 8'h11, 0, 0, 0, 1, 1, 0, 0);
    p1("dec0_pred", 6'd5, 8'h11, 1'b1, 3'd2, 2'd0);
    repeat (3) upd("nt", 6'd5, 8'h11, 0, 0, 0, 0, 1, 0, 0);
    predict("lanes", 1'b1,
            {6'd5, 6'd0, 6'd5, 6'd63}, {8'h11, 8'h00, 8'h3A, 8'h00},
            4'b1000, {3'd0, 3'd3, 3'd0, 3'd3}, {4{2'd0}});

    do_reset();
    upd("al0", 6'd0, 8'h01, 1, 1, 0, 0, 0, 1, 0);
    upd("al10", 6'd10, 8'h02, 1, 1, 0, 0, 0, 1, 0);
    repeat (3) upd("inc0", 6'd0, 8'h01, 1, 0, 1, 0, 1, 0, 0);
    repeat (3) upd("inc10", 6'd10, 8'h02, 1, 0, 1, 0, 1, 0, 0);
    fill(247);
    check("pre_wrap.busy", 32'(aging_busy_o), 32'd0);
    fill(1);
    cnt = 0;
    while (aging_busy_o && cnt < 200) begin
      cnt++;
      tick();
    end
    check("sweep_len", cnt, 32'd64);
    predict("aged", 1'b1,
            {6'd0, 6'd10, 6'd5, 6'd0}, {8'h01, 8'h02, 8'h00, 8'h99},
            4'b1100, {3'd7, 3'd7, 3'd3, 3'd7},
            {2'd1, 2'd1, 2'd0, 2'd1});
    upd("inc10b", 6'd10, 8'h02, 1, 0, 1, 0, 1, 0, 0);
    fill(254);
    check("pre_wrap2.busy", 32'(aging_busy_o), 32'd0);
    fill(1);
    check("wrap2.busy", 32'(aging_busy_o), 32'd1);
    repeat (10) tick();
    upd("sw_inc", 6'd10, 8'h02, 1, 0, 1, 0, 1, 0, 0);
    wait_idle("sweep2_end");
    predict("race", 1'b1,
            {6'd10, 6'd0, 6'd10, 6'd0}, {8'h02, 8'h01, 8'h02, 8'h01},
            4'hF, {4{3'd7}}, {2'd3, 2'd0, 2'd3, 2'd0});

    do_reset();
    upd("al0c", 6'd0, 8'h01, 1, 1, 0, 0, 0, 1, 0);
    p1("al0c_pred", 6'd0, 8'h01, 1'b1, 3'd4, 2'd0);
    fill(255);
    check("wrap3.busy", 32'(aging_busy_o), 32'd1);
    repeat (30) tick();
    rst_i = 1'b1;
    #1;
    check("midrst.busy", 32'(aging_busy_o),  32'd0);
    check("midrst.hit",  32'(predict_hit_o), 32'd0);
    check("midrst.ctr",  32'(predict_ctr_o), 32'd0);
    tick();
    rst_i = 1'b0;
    tick();
    p1("midrst_pred", 6'd0, 8'h01, 1'b0, 3'd3, 2'd0);
    fill(255);
    check("age0.busy", 32'(aging_busy_o), 32'd0);
    fill(1);
    check("age0.wrap", 32'(aging_busy_o), 32'd1);
    wait_idle("sweep3_end");

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
